// File: rtl/vj_cascade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vj_cascade_ctrl
//  Purpose  : Viola-Jones cascade sequencer. Rasters a WIN x WIN window over
//             the image, launches cascade stages in order with their
//             thresholds, rejects a window on its first failing stage and
//             queues surviving windows in a small valid/ready detection FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module vj_cascade_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_W    = 3,
    parameter int WIN        = 19,
    parameter int STEP       = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [9:0]         img_w,
    input  logic [8:0]         img_h,
    input  logic               cfg_we,
    input  logic [STAGE_W-1:0] cfg_addr,
    input  logic [31:0]        cfg_data,
    output logic               se_start,
    output logic [9:0]         se_win_x,
    output logic [8:0]         se_win_y,
    output logic [STAGE_W-1:0] se_stage_idx,
    output logic [31:0]        se_stage_threshold,
    input  logic               se_done,
    input  logic               se_pass,
    input  logic [31:0]        se_score,
    output logic               det_valid,
    input  logic               det_ready,
    output logic [9:0]         det_x,
    output logic [8:0]         det_y,
    output logic [31:0]        det_score,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        win_count,
    output logic [15:0]        det_count
);

    localparam int                 FA         = $clog2(FIFO_DEPTH);
    localparam int                 EW         = 10 + 9 + 32;
    localparam logic [10:0]        X_ADV      = 11'(STEP + WIN);
    localparam logic [9:0]         Y_ADV      = 10'(STEP + WIN);
    localparam logic [9:0]         STEP_X     = 10'(STEP);
    localparam logic [8:0]         STEP_Y     = 9'(STEP);
    localparam logic [9:0]         WIN_W      = 10'(WIN);
    localparam logic [8:0]         WIN_H      = 9'(WIN);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
    localparam logic [STAGE_W:0]   NSTAGE     = (STAGE_W + 1)'(NUM_STAGES);
    localparam logic [FA-1:0]      PTR_ONE    = FA'(1);
    localparam logic [FA:0]        CNT_ONE    = (FA + 1)'(1);
    localparam logic [FA:0]        FDEPTH     = (FA + 1)'(FIFO_DEPTH);
    localparam logic [15:0]        CNT_MAX    = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_PUSH   = 3'd3,
        S_ADV    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [9:0]           x_q, x_d;
    logic [8:0]           y_q, y_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [9:0]           imgw_q, imgw_d;
    logic [8:0]           imgh_q, imgh_d;
    logic                 busy_q, busy_d;
    logic [15:0]          wcnt_q, wcnt_d;
    logic [15:0]          dcnt_q, dcnt_d;
    logic [31:0]          score_q, score_d;

    // Table is sized to the full index range so any stage index is a legal
    // lookup; entries at or above NUM_STAGES are never written and stay 0.
    logic [31:0]          thresh_q [2**STAGE_W];

    logic [EW-1:0]        fifo_q [FIFO_DEPTH];
    logic [FA-1:0]        wptr_q, rptr_q;
    logic [FA:0]          fcnt_q;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic [EW-1:0]        head;

    assign fifo_full          = (fcnt_q == FDEPTH);
    assign det_valid          = (fcnt_q != '0);
    assign pop                = det_valid && det_ready;
    assign head               = fifo_q[rptr_q];
    assign det_x              = head[EW-1 -: 10];
    assign det_y              = head[40 -: 9];
    assign det_score          = head[31:0];

    assign se_win_x           = x_q;
    assign se_win_y           = y_q;
    assign se_stage_idx       = stage_q;
    assign se_stage_threshold = thresh_q[stage_q];
    assign busy               = busy_q;
    assign win_count          = wcnt_q;
    assign det_count          = dcnt_q;

    // Threshold table: host writes accepted only between frames and in range.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**STAGE_W; i++) begin
                thresh_q[i] <= '0;
            end
        end else if (cfg_we && !busy_q && ({1'b0, cfg_addr} < NSTAGE)) begin
            thresh_q[cfg_addr] <= cfg_data;
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            stage_q <= '0;
            imgw_q  <= '0;
            imgh_q  <= '0;
            busy_q  <= 1'b0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            stage_q <= stage_d;
            imgw_q  <= imgw_d;
            imgh_q  <= imgh_d;
            busy_q  <= busy_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
            score_q <= score_d;
        end
    end

    // Next-state, raster stepping and strobe generation.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        stage_d    = stage_q;
        imgw_d     = imgw_q;
        imgh_d     = imgh_q;
        busy_d     = busy_q;
        wcnt_d     = wcnt_q;
        dcnt_d     = dcnt_q;
        score_d    = score_q;
        se_start   = 1'b0;
        frame_done = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    imgw_d  = img_w;
                    imgh_d  = img_h;
                    x_d     = '0;
                    y_d     = '0;
                    stage_d = '0;
                    wcnt_d  = '0;
                    dcnt_d  = '0;
                    busy_d  = 1'b1;
                    // An image smaller than one window has nothing to scan.
                    if ((img_w < WIN_W) || (img_h < WIN_H)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                se_start = 1'b1;
                if ((stage_q == '0) && (wcnt_q != CNT_MAX)) begin
                    wcnt_d = wcnt_q + 16'd1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (se_done) begin
                    if (!se_pass) begin
                        state_d = S_ADV;
                    end else if (stage_q != LAST_STAGE) begin
                        stage_d = stage_q + STAGE_ONE;
                        state_d = S_LAUNCH;
                    end else begin
                        score_d = se_score;
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                // Full is judged on the registered count, so a pop in the
                // same cycle does not open a slot until the next cycle.
                if (!fifo_full) begin
                    push = 1'b1;
                    if (dcnt_q != CNT_MAX) begin
                        dcnt_d = dcnt_q + 16'd1;
                    end
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                stage_d = '0;
                if (({1'b0, x_q} + X_ADV) <= {1'b0, imgw_q}) begin
                    x_d     = x_q + STEP_X;
                    state_d = S_LAUNCH;
                end else begin
                    x_d = '0;
                    if (({1'b0, y_q} + Y_ADV) <= {1'b0, imgh_q}) begin
                        y_d     = y_q + STEP_Y;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Detection FIFO; contents survive frame end and are only lost on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= {x_q, y_q, score_q};
                wptr_q         <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                fcnt_q <= fcnt_q + CNT_ONE;
            end else if (pop && !push) begin
                fcnt_q <= fcnt_q - CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vj_cascade_ctrl.md
Name: vj_cascade_ctrl

Overview:
- Downstream sequencer for the per-stage weak-classifier evaluator.
- Rasters a 19x19 detection window across an image already held in integral RAM.
- For each window, launches cascade stages in order, supplies each stage's threshold, and rejects the window early on the first stage fail.
- Windows that pass every stage are pushed into a small valid/ready detection FIFO.

Parameters:
- NUM_STAGES, 4, number of cascade stages (>=1)
- STAGE_W, 3, stage index width; must satisfy 2^STAGE_W >= NUM_STAGES
- WIN, 19, window side in pixels
- STEP, 1, window stride in x and y (>=1)
- FIFO_DEPTH, 4, detection FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin frame scan; sampled in IDLE only
- img_w  in  10  image width in pixels; sampled on accepted start
- img_h  in  9  image height in pixels; sampled on accepted start
- cfg_we  in  1  threshold table write strobe
- cfg_addr  in  STAGE_W  stage index to write
- cfg_data  in  32  signed stage threshold
- se_start  out  1  one-cycle launch pulse to stage evaluator
- se_win_x  out  10  window x
- se_win_y  out  9  window y
- se_stage_idx  out  STAGE_W  stage being evaluated
- se_stage_threshold  out  32  thresh_mem[se_stage_idx], combinational
- se_done  in  1  evaluator completion pulse
- se_pass  in  1  stage result; valid with se_done
- se_score  in  32  signed stage score; valid with se_done
- det_valid  out  1  FIFO head valid
- det_ready  in  1  consumer accepts head
- det_x  out  10  detection x
- det_y  out  9  detection y
- det_score  out  32  final-stage score
- busy  out  1  scan in progress
- frame_done  out  1  one-cycle pulse at scan end
- win_count  out  16  windows started this frame, saturating
- det_count  out  16  detections pushed this frame, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; x, y, stage_idx 0; FIFO empty; thresh_mem all 0.
- cfg_we writes thresh_mem[cfg_addr] <= cfg_data.
  - Ignored while busy=1.
  - Ignored when cfg_addr >= NUM_STAGES.
- IDLE:
  - On start: latch img_w/img_h; clear x, y, counters; busy <= 1.
  - If img_w < WIN or img_h < WIN, go to DONE; otherwise go to LAUNCH.
  - start while busy is ignored.
- LAUNCH: se_start=1 for exactly one cycle with current x, y, stage_idx; go to WAIT.
  - If stage_idx==0, win_count increments.
- WAIT: hold until se_done.
  - se_pass=0: go to ADV.
  - se_pass=1 and stage_idx<NUM_STAGES-1: stage_idx++, go to LAUNCH.
  - se_pass=1 and final stage: latch se_score, go to PUSH.
- PUSH:
  - If FIFO not full (registered count < FIFO_DEPTH): write {x, y, score}, det_count++, go to ADV.
  - Otherwise stall in PUSH. No detection is ever dropped.
- ADV: stage_idx <= 0.
  - If x+STEP+WIN <= img_w: x += STEP, go to LAUNCH.
  - Else x <= 0. If y+STEP+WIN <= img_h: y += STEP, go to LAUNCH.
  - Else go to DONE.
- DONE: frame_done=1 for one cycle; busy <= 0; go to IDLE. FIFO contents persist for draining.
- Raster order: x fastest; windows cover x in 0..img_w-WIN and y in 0..img_h-WIN at stride STEP.
- Arithmetic: bound compares use 11-bit (x) / 10-bit (y) intermediates so there is no wrap. Counters saturate at 16'hFFFF.
- FIFO:
  - det_* show the head; det_valid = !empty.
  - Pop when det_valid && det_ready.
  - Push and pop in the same cycle (not full) leaves the count unchanged.
  - When full, a same-cycle pop does not admit a push; the push proceeds the next cycle.
- se_done outside WAIT is ignored.
- Reset mid-frame: immediate return to reset state; FIFO flushed; thresholds cleared.

Test Plan:
- Thresholds written {10,20,30,40}; img 19x19; evaluator passes all -> 4 se_start pulses with se_stage_idx 0..3 and se_stage_threshold 10,20,30,40. Then one detection (0,0,score of stage 3), win_count=1, det_count=1, frame_done once.
- img 21x20, STEP=1, evaluator fails stage 0 always -> 6 windows in order (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); exactly 6 se_start pulses, all stage 0; det_count=0.
- img 21x21, fail at stage 2 for window (1,1) only, else pass -> 8 detections in raster order; window (1,1) receives exactly 3 launches.
- det_ready=0, all windows pass, img 23x19 (5 windows) -> FIFO fills at 4, controller stalls in PUSH with busy=1. Raise det_ready -> 5th detection pushed, then frame_done.
- img_w=18 -> zero se_start pulses, frame_done pulse 2 cycles after start, win_count=0.
- Assert reset_n low while in WAIT -> busy, det_valid, and se_start are 0 immediately. Rerunning a frame with no cfg writes shows se_stage_threshold=0.
